mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_starve_ctr.sv | 29 ++
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter: FSM encoding,
// requester IDs and starvation counter width.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DUMP   = 3'd3,
    HALTED = 3'd4
  } arb_state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int CTR_W = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive data grants taken while fetch was waiting.
// clr has priority over inc; at_max flags the saturation value.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [CTR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CTR_W'(MAX))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == CTR_W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between fetch and data requesters and owns the
// halt-time dump. Optional misaligned-access trap: define MEM_ARB_ALIGN_CHECK_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  input  logic              halt,
  output logic              m_en,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_createdump,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_done,
  input  logic              m_busy,
  output logic              err
);

  arb_state_t        state;
  logic              cur_wr;
  logic              at_max;
  logic              winner;
  logic              grant;
  logic              grant_i;
  logic              grant_d;
  logic              mis;
  logic              done_i;
  logic              done_d;
  logic [ADDR_W-1:0] win_addr;

  // Issue happens in the request cycle, so arbitration and memory-side
  // outputs are combinational; rst masks every output.
  always_comb begin
    winner   = (d_req && !(at_max && if_req)) ? PORT_D : PORT_I;
    win_addr = (winner == PORT_D) ? d_addr : if_addr;
    grant    = !rst && (state == IDLE) && !halt && (if_req || d_req) && !m_busy;
    grant_d  = grant && (winner == PORT_D);
    grant_i  = grant && (winner == PORT_I);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    mis      = grant && win_addr[0];
`else
    mis      = 1'b0;
`endif
    done_i   = !rst && (state == BUSY_I) && m_done;
    done_d   = !rst && (state == BUSY_D) && m_done;

    m_en         = grant && !mis;
    m_wr         = m_en && grant_d && d_wr;
    m_addr       = m_en ? win_addr : '0;
    m_wdata      = (m_en && grant_d && d_wr) ? d_wdata : '0;
    m_createdump = !rst && (state == DUMP);
    err          = mis;

    if_done  = done_i || (grant_i && mis);
    d_done   = done_d || (grant_d && mis);
    if_rdata = done_i ? m_rdata : '0;
    d_rdata  = (done_d && !cur_wr) ? m_rdata : '0;
    if_stall = !rst && if_req && !if_done;
    d_stall  = !rst && d_req && !d_done;
  end

  mem_arb_starve_ctr #(
    .MAX(STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .inc   (grant_d && if_req),
    .clr   (grant_i || (grant_d && !if_req)),
    .at_max(at_max)
  );

  // A trapped misaligned grant completes in place and stays in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cur_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (halt) begin
            state <= DUMP;
          end else if (grant && !mis) begin
            state  <= (winner == PORT_D) ? BUSY_D : BUSY_I;
            cur_wr <= (winner == PORT_D) && d_wr;
          end
        end
        BUSY_I, BUSY_D: begin
          if (m_done) state <= IDLE;
        end
        DUMP:    state <= HALTED;
        HALTED:  state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs change just after
// posedge, outputs are sampled on the following negedge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        d_stall;
  logic        halt;
  logic        m_en;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic        m_createdump;
  logic [15:0] m_rdata;
  logic        m_done;
  logic        m_busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(16),
    .DATA_W(16),
    .STARVE_MAX(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_done     (if_done),
    .if_stall    (if_stall),
    .d_req       (d_req),
    .d_wr        (d_wr),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_done      (d_done),
    .d_stall     (d_stall),
    .halt        (halt),
    .m_en        (m_en),
    .m_wr        (m_wr),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_createdump(m_createdump),
    .m_rdata     (m_rdata),
    .m_done      (m_done),
    .m_busy      (m_busy),
    .err         (err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [15:0] ia, input logic dr,
                               input logic dw, input logic [15:0] da, input logic [15:0] dwd,
                               input logic h, input logic md, input logic [15:0] mrd);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_wr    = dw;
    d_addr  = da;
    d_wdata = dwd;
    halt    = h;
    m_done  = md;
    m_rdata = mrd;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  logic exp_d [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    rst    = 1'b1;
    m_busy = 1'b0;
    // Reset with requests pending: everything must stay quiet.
    applyStimulus(1'b1, 16'h0010, 1'b1, 1'b1, 16'h0200, 16'h1234, 1'b0, 1'b1, 16'hFFFF);
    settle();
    checkOutput("rst_m_en", 32'(m_en), 32'd0);
    checkOutput("rst_if_stall", 32'(if_stall), 32'd0);
    checkOutput("rst_d_done", 32'(d_done), 32'd0);
    checkOutput("rst_if_rdata", 32'(if_rdata), 32'd0);
    nextCycle();
    nextCycle();
    rst = 1'b0;
    checkOutput("rst_ctr", 32'(dut.u_starve.cnt), 32'd0);

    // Test 1: memory busy holds off the fetch, then single fetch, done 2 cycles later.
    m_busy = 1'b1;
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    settle();
    checkOutput("t1_busy_en", 32'(m_en), 32'd0);
    checkOutput("t1_busy_stall", 32'(if_stall), 32'd1);
    nextCycle();
    m_busy = 1'b0;
    settle();
    checkOutput("t1_c0_en", 32'(m_en), 32'd1);
    checkOutput("t1_c0_addr", 32'(m_addr), 32'h0010);
    checkOutput("t1_c0_wr", 32'(m_wr), 32'd0);
    checkOutput("t1_c0_stall", 32'(if_stall), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hDEAD);
    settle();
    checkOutput("t1_c1_en", 32'(m_en), 32'd0);
    checkOutput("t1_c1_done", 32'(if_done), 32'd0);
    checkOutput("t1_c1_rdata", 32'(if_rdata), 32'd0);
    checkOutput("t1_c1_stall", 32'(if_stall), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hABCD);
    settle();
    checkOutput("t1_c2_done", 32'(if_done), 32'd1);
    checkOutput("t1_c2_rdata", 32'(if_rdata), 32'hABCD);
    checkOutput("t1_c2_stall", 32'(if_stall), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    settle();
    checkOutput("t1_c3_done", 32'(if_done), 32'd0);
    nextCycle();

    // Test 2: simultaneous fetch and store; store goes first.
    applyStimulus(1'b1, 16'h0020, 1'b1, 1'b1, 16'h0200, 16'h1234, 1'b0, 1'b0, 16'h0000);
    settle();
    checkOutput("t2_st_en", 32'(m_en), 32'd1);
    checkOutput("t2_st_wr", 32'(m_wr), 32'd1);
    checkOutput("t2_st_addr", 32'(m_addr), 32'h0200);
    checkOutput("t2_st_wdata", 32'(m_wdata), 32'h1234);
    checkOutput("t2_if_stall", 32'(if_stall), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 16'h0020, 1'b1, 1'b1, 16'h0200, 16'h1234, 1'b0, 1'b1, 16'h5555);
    settle();
    checkOutput("t2_d_done", 32'(d_done), 32'd1);
    checkOutput("t2_d_rdata", 32'(d_rdata), 32'd0);
    checkOutput("t2_if_done", 32'(if_done), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    settle();
    checkOutput("t2_if_en", 32'(m_en), 32'd1);
    checkOutput("t2_if_addr", 32'(m_addr), 32'h0020);
    checkOutput("t2_if_wr", 32'(m_wr), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0F0F);
    settle();
    checkOutput("t2_if_rdata", 32'(if_rdata), 32'h0F0F);
    nextCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    nextCycle();

    // Test 3: both requests held, latency 1, expect D,D,D,D,I,D.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 16'h0040, 1'b1, 1'b0, 16'h0300, 16'h0000, 1'b0, 1'b0, 16'h0000);
      settle();
      checkOutput($sformatf("t3_en_%0d", i), 32'(m_en), 32'd1);
      checkOutput($sformatf("t3_addr_%0d", i), 32'(m_addr), exp_d[i] ? 32'h0300 : 32'h0040);
      nextCycle();
      applyStimulus(1'b1, 16'h0040, 1'b1, 1'b0, 16'h0300, 16'h0000, 1'b0, 1'b1, 16'h1000 + 16'(i));
      settle();
      checkOutput($sformatf("t3_d_done_%0d", i), 32'(d_done), 32'(exp_d[i]));
      checkOutput($sformatf("t3_if_done_%0d", i), 32'(if_done), 32'(!exp_d[i]));
      nextCycle();
    end
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    nextCycle();

    // Test 4: halt arrives while a load is in flight.
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0400, 16'h0000, 1'b0, 1'b0, 16'h0000);
    settle();
    checkOutput("t4_en", 32'(m_en), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0400, 16'h0000, 1'b1, 1'b0, 16'h0000);
    settle();
    checkOutput("t4_wait_done", 32'(d_done), 32'd0);
    checkOutput("t4_wait_dump", 32'(m_createdump), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0400, 16'h0000, 1'b1, 1'b1, 16'h7777);
    settle();
    checkOutput("t4_d_done", 32'(d_done), 32'd1);
    checkOutput("t4_d_rdata", 32'(d_rdata), 32'h7777);
    checkOutput("t4_dump_early", 32'(m_createdump), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000);
    settle();
    checkOutput("t4_idle_en", 32'(m_en), 32'd0);
    checkOutput("t4_idle_dump", 32'(m_createdump), 32'd0);
    nextCycle();
    settle();
    checkOutput("t4_dump", 32'(m_createdump), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 16'h0080, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h9999);
    for (int i = 0; i < 3; i++) begin
      settle();
      checkOutput($sformatf("t4_halt_dump_%0d", i), 32'(m_createdump), 32'd0);
      checkOutput($sformatf("t4_halt_stall_%0d", i), 32'(if_stall), 32'd1);
      checkOutput($sformatf("t4_halt_en_%0d", i), 32'(m_en), 32'd0);
      checkOutput($sformatf("t4_halt_done_%0d", i), 32'(if_done), 32'd0);
      nextCycle();
    end

    // Test 5: reset out of HALTED, then reset mid-fetch.
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b1, 16'h0050, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    settle();
    checkOutput("t5_en", 32'(m_en), 32'd1);
    checkOutput("t5_addr", 32'(m_addr), 32'h0050);
    nextCycle();
    rst = 1'b1;
    applyStimulus(1'b1, 16'h0050, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h3333);
    settle();
    checkOutput("t5_rst_done", 32'(if_done), 32'd0);
    checkOutput("t5_rst_rdata", 32'(if_rdata), 32'd0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h3333);
    settle();
    checkOutput("t5_post_done", 32'(if_done), 32'd0);
    checkOutput("t5_post_en", 32'(m_en), 32'd0);
    checkOutput("t5_post_ctr", 32'(dut.u_starve.cnt), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 16'h0060, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    settle();
    checkOutput("t5_new_en", 32'(m_en), 32'd1);
    checkOutput("t5_new_addr", 32'(m_addr), 32'h0060);
    nextCycle();
    applyStimulus(1'b1, 16'h0060, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h4444);
    settle();
    checkOutput("t5_new_done", 32'(if_done), 32'd1);
    checkOutput("t5_new_rdata", 32'(if_rdata), 32'h4444);
    nextCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    nextCycle();

    // Test 6: odd-address load.
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0101, 16'h0000, 1'b0, 1'b0, 16'h6666);
    settle();
`ifdef MEM_ARB_ALIGN_CHECK_EN
    checkOutput("t6_err", 32'(err), 32'd1);
    checkOutput("t6_done", 32'(d_done), 32'd1);
    checkOutput("t6_en", 32'(m_en), 32'd0);
    checkOutput("t6_rdata", 32'(d_rdata), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    settle();
    checkOutput("t6_after_err", 32'(err), 32'd0);
    checkOutput("t6_after_en", 32'(m_en), 32'd0);
`else
    checkOutput("t6_err", 32'(err), 32'd0);
    checkOutput("t6_en", 32'(m_en), 32'd1);
    checkOutput("t6_addr", 32'(m_addr), 32'h0101);
    checkOutput("t6_done", 32'(d_done), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0101, 16'h0000, 1'b0, 1'b1, 16'h6666);
    settle();
    checkOutput("t6_load_done", 32'(d_done), 32'd1);
    checkOutput("t6_load_rdata", 32'(d_rdata), 32'h6666);
`endif
    nextCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
